gamepad_pmod_tx: RTL
====================

Name: gamepad_pmod_tx

Overview:
Transmit end of the gamepad Pmod link. Serialises two SNES-style controller states onto pmod_latch / pmod_clk / pmod_data in the exact format consumed by gamepad_pmod_single. Used as an on-chip stimulus source for gamepad emulation and self-test, and as a bench driver for the receiver and ai_controller paths. Runs entirely in the system clock domain; outputs are registered.

Parameters:
HALF_BIT, 4, system clocks per pmod_clk half-period (min 2).
LATCH_CYC, 4, system clocks pmod_latch is held high (min 1).
GAP_CYC, 8, idle system clocks after latch before the next frame may start (min 1).
FRAME_PERIOD, 416667, system clocks between auto-started frames (auto mode only).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
buttons1  in  12  controller 1 state, 1=pressed; [11..0]=B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R
present1  in  1  controller 1 connected
buttons2  in  12  controller 2 state, same bit order
present2  in  1  controller 2 connected
send  in  1  single-cycle request to transmit one frame
busy  out  1  high from frame acceptance until GAP done
done  out  1  one-cycle pulse on the last GAP cycle
pmod_latch  out  1  latch strobe to receiver
pmod_clk  out  1  shift clock to receiver
pmod_data  out  1  serial data to receiver

Behaviour:
- Reset (sync, rst_n=0 at clk edge): state IDLE, busy=0, done=0, pmod_latch=0, pmod_clk=0, pmod_data=0, bit counter=0, divider=0. Reset mid-frame aborts immediately; no partial latch is ever emitted.
- Frame word (24 bits) snapshotted on acceptance: {slot2, slot1}; slotN = presentN ? buttonsN : 12'hFFF (all-ones is the receiver's absent signature). Inputs changing during a frame have no effect.
- Shifted MSB first, so slot1 ends in the receiver's low 12 bits.
- States:
  - IDLE: send=1 -> accept, busy=1 the next cycle; enter SHIFT_LO with bit index 23.
  - SHIFT_LO: pmod_clk=0, pmod_data=word[idx]; hold HALF_BIT cycles -> SHIFT_HI.
  - SHIFT_HI: pmod_clk=1, data unchanged (receiver samples on rising edge); hold HALF_BIT cycles.
    - idx>0 -> idx-1, SHIFT_LO.
    - idx=0 -> LATCH.
  - LATCH: pmod_clk=0, pmod_latch=1 for LATCH_CYC cycles -> GAP.
  - GAP: latch=0, data=0, GAP_CYC cycles; done pulses on the last one -> IDLE with busy=0.
- Timing: data changes only while pmod_clk is low. Exactly 24 rising pmod_clk edges per frame, each followed by exactly one latch pulse. Frame length = 48*HALF_BIT + LATCH_CYC + GAP_CYC cycles.
- send while busy=1 is ignored, not queued. send on the same cycle done pulses is also ignored. send in the first IDLE cycle is accepted.
- Divider width: clog2 of the max of HALF_BIT, LATCH_CYC and GAP_CYC. Bit index is 5 bits.

Optional Feature:
GAMEPAD_TX_AUTO_EN:
- Defined: free-running frame-period counter, reset to 0. A frame auto-starts when the counter reaches FRAME_PERIOD-1, then the counter wraps. Ignored if busy, as for send; send still works. FRAME_PERIOD must exceed the frame length.
- Undefined: counter absent; frames start only on send.

Decomposition:
- Package gamepad_pmod_pkg:
  - state enum (IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP)
  - button bit-index localparams (BTN_B=11 .. BTN_R=0)
  - BITS_PER_SLOT=12, FRAME_BITS=24, ABSENT_SLOT=12'hFFF
  - shared with gamepad_pmod_single.
- Sub-module pmod_phase_timer: loadable down-counter with a terminal-count flag, reused for the half-bit, latch and gap phases.

Test Plan:
- Loopback into gamepad_pmod_single: buttons1=12'h080 (Up), present1=1, present2=0, pulse send -> after done, receiver up=1, all other buttons=0, is_present=1.
- present1=0, buttons1=12'h0AA, pulse send -> receiver is_present=0. Monitor sees 24 bits, all 1s.
- HALF_BIT=4, LATCH_CYC=4, GAP_CYC=8 -> busy high exactly 204 cycles. pmod_data is never toggled while pmod_clk=1. Exactly 24 clk rising edges and 1 latch pulse per frame.
- send re-pulsed at frame cycles 1, 100, and on the done cycle -> exactly one frame and one done pulse.
- rst_n=0 at cycle 50 of a frame -> next cycle all outputs 0 and busy=0. No latch pulse seen by the receiver; its previous button state is retained.
- With GAMEPAD_TX_AUTO_EN and FRAME_PERIOD=500, no send -> frames start at cycles 499, 999, 1499 after reset. Without the macro, no frame is ever observed.

Source files
------------

// File: rtl/gamepad_pmod_pkg.sv
// -----------------------------------------------------------------------------
// gamepad_pmod_pkg
// Shared definitions for the gamepad Pmod link (transmitter and receiver).
//   state_t        : transmitter phase encoding
//   BTN_*          : bit positions of each button inside a 12-bit slot
//   BITS_PER_SLOT  : bits carried per controller
//   FRAME_BITS     : bits carried per frame (two slots)
//   ABSENT_SLOT    : slot value signalling "no controller connected"
//   slot_value()   : selects the slot content for one controller
// -----------------------------------------------------------------------------
package gamepad_pmod_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        GAP      = 3'd4
    } state_t;

    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    localparam int                 BITS_PER_SLOT = 12;
    localparam int                 FRAME_BITS    = 24;
    localparam logic [BITS_PER_SLOT-1:0] ABSENT_SLOT = 12'hFFF;

    // A disconnected controller is sent as all-ones so the receiver can
    // tell it apart from a connected pad with nothing pressed.
    function automatic logic [BITS_PER_SLOT-1:0] slot_value(
        input logic                     present,
        input logic [BITS_PER_SLOT-1:0] buttons
    );
        return present ? buttons : ABSENT_SLOT;
    endfunction

endpackage

// File: rtl/pmod_phase_timer.sv
// -----------------------------------------------------------------------------
// pmod_phase_timer
// Loadable down-counter that times one phase of the Pmod frame (half-bit,
// latch or gap). Loading N-1 gives a phase of N cycles; o_tc is high in the
// final cycle of the phase. The counter parks at zero when not reloaded.
// Ports:
//   clk        : system clock
//   rst_n      : synchronous active-low reset (count -> 0)
//   i_load     : load i_load_val this cycle (priority over counting)
//   i_load_val : value to load (phase length minus one)
//   o_count    : current count
//   o_tc       : terminal count, o_count == 0
// -----------------------------------------------------------------------------
module pmod_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/gamepad_pmod_tx.sv
// -----------------------------------------------------------------------------
// gamepad_pmod_tx
// Transmit end of the gamepad Pmod link. Serialises two 12-bit controller
// states MSB first on pmod_clk/pmod_data, then strobes pmod_latch, then idles
// for a gap. Frame length = 48*HALF_BIT + LATCH_CYC + GAP_CYC cycles.
// All outputs are registered.
// Optional build macro GAMEPAD_TX_AUTO_EN: adds a free-running period
// counter that starts a frame every FRAME_PERIOD cycles.
// Ports:
//   clk, rst_n           : system clock, synchronous active-low reset
//   buttons1, present1   : controller 1 state (1=pressed) and connect flag
//   buttons2, present2   : controller 2 state and connect flag
//   send                 : one-cycle frame request (ignored while busy)
//   busy                 : frame in progress, acceptance through gap
//   done                 : pulse in the last gap cycle
//   pmod_latch/clk/data  : serial link to the receiver
// -----------------------------------------------------------------------------
module gamepad_pmod_tx
    import gamepad_pmod_pkg::*;
#(
    parameter int HALF_BIT     = 4,
    parameter int LATCH_CYC    = 4,
    parameter int GAP_CYC      = 8,
    parameter int FRAME_PERIOD = 416667
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] buttons1,
    input  logic        present1,
    input  logic [11:0] buttons2,
    input  logic        present2,
    input  logic        send,
    output logic        busy,
    output logic        done,
    output logic        pmod_latch,
    output logic        pmod_clk,
    output logic        pmod_data
);

    localparam int MAX_HL  = (HALF_BIT > LATCH_CYC) ? HALF_BIT : LATCH_CYC;
    localparam int MAX_CYC = (MAX_HL > GAP_CYC) ? MAX_HL : GAP_CYC;
    localparam int DIV_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [DIV_W-1:0] LD_HALF  = DIV_W'(HALF_BIT - 1);
    localparam logic [DIV_W-1:0] LD_LATCH = DIV_W'(LATCH_CYC - 1);
    localparam logic [DIV_W-1:0] LD_GAP   = DIV_W'(GAP_CYC - 1);

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_word;
    logic [4:0]              r_idx;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_latch;
    logic                    r_pclk;
    logic                    r_pdata;

    logic                    w_start;
    logic                    w_accept;
    logic [FRAME_BITS-1:0]   w_word_next;
    logic [4:0]              w_idx_dec;
    logic                    w_load;
    logic [DIV_W-1:0]        w_load_val;
    logic [DIV_W-1:0]        w_count;
    logic                    w_tc;

`ifdef GAMEPAD_TX_AUTO_EN
    localparam int PER_W = ($clog2(FRAME_PERIOD) < 1) ? 1 : $clog2(FRAME_PERIOD);

    logic [PER_W-1:0] r_period_cnt;
    logic             w_auto_fire;

    assign w_auto_fire = (r_period_cnt == PER_W'(FRAME_PERIOD - 1));

    // Free-running; a tick that lands while a frame is in flight is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
        end else if (w_auto_fire) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + PER_W'(1);
        end
    end

    assign w_start = send | w_auto_fire;
`else
    logic w_unused_period;
    assign w_unused_period = (FRAME_PERIOD > 0);
    assign w_start         = send;
`endif

    assign w_accept    = (r_state == IDLE) && w_start;
    assign w_word_next = {slot_value(present2, buttons2), slot_value(present1, buttons1)};
    assign w_idx_dec   = r_idx - 5'd1;

    // Phase timer reload: each phase loads its length on entry.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = LD_HALF;
        case (r_state)
            IDLE: begin
                w_load     = w_accept;
                w_load_val = LD_HALF;
            end
            SHIFT_LO: begin
                w_load     = w_tc;
                w_load_val = LD_HALF;
            end
            SHIFT_HI: begin
                w_load     = w_tc;
                w_load_val = (r_idx != 5'd0) ? LD_HALF : LD_LATCH;
            end
            LATCH: begin
                w_load     = w_tc;
                w_load_val = LD_GAP;
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = LD_HALF;
            end
        endcase
    end

    pmod_phase_timer #(
        .W (DIV_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_latch <= 1'b0;
            r_pclk  <= 1'b0;
            r_pdata <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_word  <= w_word_next;
                        r_idx   <= 5'(FRAME_BITS - 1);
                        r_busy  <= 1'b1;
                        r_pclk  <= 1'b0;
                        r_pdata <= w_word_next[FRAME_BITS-1];
                        r_state <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (w_tc) begin
                        r_pclk  <= 1'b1;
                        r_state <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (w_tc) begin
                        // Data only moves together with the falling clock edge.
                        r_pclk <= 1'b0;
                        if (r_idx != 5'd0) begin
                            r_idx   <= w_idx_dec;
                            r_pdata <= r_word[w_idx_dec];
                            r_state <= SHIFT_LO;
                        end else begin
                            r_pdata <= 1'b0;
                            r_latch <= 1'b1;
                            r_state <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (w_tc) begin
                        r_latch <= 1'b0;
                        // A one-cycle gap is its own last cycle.
                        r_done  <= (GAP_CYC == 1);
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (w_tc) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_done <= (w_count == DIV_W'(1));
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_latch <= 1'b0;
                    r_pclk  <= 1'b0;
                    r_pdata <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pmod_latch = r_latch;
    assign pmod_clk   = r_pclk;
    assign pmod_data  = r_pdata;

endmodule
